// File: rtl/lb_pkg.sv
// Shared definitions for the load-balancing dispatcher: FSM state encoding and
// the layout of the lb_ctrl word (two OPERATOR_ID_WIDTH-wide fields).
package lb_pkg;

  typedef enum logic [2:0] {
    IDLE,
    HDR,
    BDY,
    DROP_HDR,
    DROP_BDY
  } lb_state_e;

  // lb_ctrl field positions, in units of OPERATOR_ID_WIDTH
  localparam int CTRL_FIELDS  = 2;
  localparam int REGION_FIELD = 1;
  localparam int OP_ID_FIELD  = 0;

  function automatic int sel_width(input int n_regions);
    return (n_regions > 1) ? $clog2(n_regions) : 1;
  endfunction

endpackage

// File: rtl/lb_region_counter.sv
// Saturating up/down occupancy counter for one downstream region.
// Simultaneous increment and decrement cancel out.
module lb_region_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             inc_i,
  input  logic             dec_i,
  output logic [WIDTH-1:0] count_o
);

  logic [WIDTH-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (inc_i && !dec_i && (count_q != '1)) begin
      count_d = count_q + WIDTH'(1);
    end else if (dec_i && !inc_i && (count_q != '0)) begin
      count_d = count_q - WIDTH'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/lb_dispatcher.sv
// Routes one header+body packet per lb_ctrl request to the selected region and
// keeps per-region outstanding-request counts. Define LB_DISPATCH_DROP_CNT_EN to add drop_cnt.
module lb_dispatcher
  import lb_pkg::*;
#(
  parameter int N_REGIONS         = 4,
  parameter int OPERATOR_ID_WIDTH = 16,
  parameter int DATA_BITS         = 512
) (
  input  logic                                   aclk,
  input  logic                                   aresetn,
  input  logic [CTRL_FIELDS*OPERATOR_ID_WIDTH-1:0] lb_ctrl,
  input  logic                                   lb_ctrl_valid,
  output logic                                   lb_ctrl_ready,
  input  logic [DATA_BITS-1:0]                   hdr_tdata,
  input  logic [DATA_BITS/8-1:0]                 hdr_tkeep,
  input  logic                                   hdr_tlast,
  input  logic                                   hdr_tvalid,
  output logic                                   hdr_tready,
  input  logic [DATA_BITS-1:0]                   bdy_tdata,
  input  logic [DATA_BITS/8-1:0]                 bdy_tkeep,
  input  logic                                   bdy_tlast,
  input  logic                                   bdy_tvalid,
  output logic                                   bdy_tready,
  output logic [N_REGIONS*DATA_BITS-1:0]         out_tdata,
  output logic [N_REGIONS*DATA_BITS/8-1:0]       out_tkeep,
  output logic [N_REGIONS-1:0]                   out_tlast,
  output logic [N_REGIONS-1:0]                   out_tvalid,
  output logic [N_REGIONS-1:0]                   out_tuser,
  input  logic [N_REGIONS-1:0]                   out_tready,
  input  logic [N_REGIONS-1:0]                   req_done,
  output logic [N_REGIONS*OPERATOR_ID_WIDTH-1:0] region_stats_out
`ifdef LB_DISPATCH_DROP_CNT_EN
  ,
  output logic [OPERATOR_ID_WIDTH-1:0]           drop_cnt
`endif
);

  localparam int W     = OPERATOR_ID_WIDTH;
  localparam int KB    = DATA_BITS / 8;
  localparam int SEL_W = sel_width(N_REGIONS);

  lb_state_e        state_q, state_d;
  logic [SEL_W-1:0] sel_q, sel_d;
  logic [W-1:0]     op_id_q, op_id_d;
  logic             run_q;

  logic [W-1:0]          region_field, op_id_field;
  logic                  region_ok, accept;
  logic                  route_en, route_bdy;
  logic [N_REGIONS-1:0]  sel_hit, inc;
  logic                  cur_valid, cur_last, cur_ready;
  logic [DATA_BITS-1:0]  cur_data;
  logic [KB-1:0]         cur_keep;
  logic                  op_id_unused;

  assign region_field = lb_ctrl[REGION_FIELD*W +: W];
  assign op_id_field  = lb_ctrl[OP_ID_FIELD*W +: W];
  assign region_ok    = region_field < W'(N_REGIONS);

  // run_q keeps the request port closed while reset is asserted and until the first clock after release
  assign lb_ctrl_ready = run_q && (state_q == IDLE);
  assign accept        = lb_ctrl_ready && lb_ctrl_valid;

  assign route_bdy = (state_q == BDY);
  assign route_en  = (state_q == HDR) || route_bdy;
  assign cur_valid = route_bdy ? bdy_tvalid : hdr_tvalid;
  assign cur_last  = route_bdy ? bdy_tlast  : hdr_tlast;
  assign cur_data  = route_bdy ? bdy_tdata  : hdr_tdata;
  assign cur_keep  = route_bdy ? bdy_tkeep  : hdr_tkeep;
  assign cur_ready = |(out_tready & sel_hit);

  // The operator ID is captured with the request but not consumed by the datapath
  assign op_id_unused = ^op_id_q;

  genvar gi;
  generate
    for (gi = 0; gi < N_REGIONS; gi++) begin : g_region
      assign sel_hit[gi]                         = route_en && (sel_q == SEL_W'(gi));
      assign out_tvalid[gi]                      = sel_hit[gi] && cur_valid;
      assign out_tlast[gi]                       = sel_hit[gi] && cur_last;
      assign out_tuser[gi]                       = sel_hit[gi] && route_bdy;
      assign out_tdata[gi*DATA_BITS +: DATA_BITS] = sel_hit[gi] ? cur_data : '0;
      assign out_tkeep[gi*KB +: KB]              = sel_hit[gi] ? cur_keep : '0;
      assign inc[gi] = accept && region_ok && (region_field == W'(gi));

      lb_region_counter #(
        .WIDTH(W)
      ) u_cnt (
        .clk_i  (aclk),
        .rst_ni (aresetn),
        .inc_i  (inc[gi]),
        .dec_i  (req_done[gi]),
        .count_o(region_stats_out[gi*W +: W])
      );
    end
  endgenerate

  always_comb begin
    state_d    = state_q;
    sel_d      = sel_q;
    op_id_d    = op_id_q;
    hdr_tready = 1'b0;
    bdy_tready = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          sel_d   = region_field[SEL_W-1:0];
          op_id_d = op_id_field;
          state_d = region_ok ? HDR : DROP_HDR;
        end
      end
      HDR: begin
        hdr_tready = cur_ready;
        if (hdr_tvalid && cur_ready && hdr_tlast) state_d = BDY;
      end
      BDY: begin
        bdy_tready = cur_ready;
        if (bdy_tvalid && cur_ready && bdy_tlast) state_d = IDLE;
      end
      DROP_HDR: begin
        hdr_tready = 1'b1;
        if (hdr_tvalid && hdr_tlast) state_d = DROP_BDY;
      end
      DROP_BDY: begin
        bdy_tready = 1'b1;
        if (bdy_tvalid && bdy_tlast) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q <= IDLE;
      sel_q   <= '0;
      op_id_q <= '0;
      run_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      op_id_q <= op_id_d;
      run_q   <= 1'b1;
    end
  end

`ifdef LB_DISPATCH_DROP_CNT_EN
  logic [W-1:0] drop_cnt_q;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      drop_cnt_q <= '0;
    end else if (accept && !region_ok && (drop_cnt_q != '1)) begin
      drop_cnt_q <= drop_cnt_q + W'(1);
    end
  end

  assign drop_cnt = drop_cnt_q;
`endif

endmodule

// File: tb/tb_lb_dispatcher.sv
// Directed bench for lb_dispatcher: table of packets plus hand-written reset,
// coincident-update and saturation sequences (second, narrow-counter instance).
module tb_lb_dispatcher;

  localparam int N  = 4;
  localparam int W  = 16;
  localparam int D  = 64;
  localparam int KB = D / 8;

  logic              aclk = 1'b0;
  logic              aresetn;
  logic [2*W-1:0]    lb_ctrl;
  logic              lb_ctrl_valid, lb_ctrl_ready;
  logic [D-1:0]      hdr_tdata, bdy_tdata;
  logic [KB-1:0]     hdr_tkeep, bdy_tkeep;
  logic              hdr_tlast, hdr_tvalid, hdr_tready;
  logic              bdy_tlast, bdy_tvalid, bdy_tready;
  logic [N*D-1:0]    out_tdata;
  logic [N*KB-1:0]   out_tkeep;
  logic [N-1:0]      out_tlast, out_tvalid, out_tuser, out_tready, req_done;
  logic [N*W-1:0]    region_stats_out;
`ifdef LB_DISPATCH_DROP_CNT_EN
  logic [W-1:0]      drop_cnt;
  logic [3:0]        s_drop_cnt;
`endif

  // narrow instance for counter saturation
  logic [7:0]  s_lb_ctrl;
  logic        s_lb_ctrl_valid, s_lb_ctrl_ready;
  logic [7:0]  s_hdr_tdata, s_bdy_tdata;
  logic [0:0]  s_hdr_tkeep, s_bdy_tkeep;
  logic        s_hdr_tlast, s_hdr_tvalid, s_hdr_tready;
  logic        s_bdy_tlast, s_bdy_tvalid, s_bdy_tready;
  logic [31:0] s_out_tdata;
  logic [3:0]  s_out_tkeep, s_out_tlast, s_out_tvalid, s_out_tuser, s_out_tready, s_req_done;
  logic [15:0] s_stats;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 aclk = ~aclk;

  lb_dispatcher #(.N_REGIONS(N), .OPERATOR_ID_WIDTH(W), .DATA_BITS(D)) dut (
    .aclk(aclk), .aresetn(aresetn),
    .lb_ctrl(lb_ctrl), .lb_ctrl_valid(lb_ctrl_valid), .lb_ctrl_ready(lb_ctrl_ready),
    .hdr_tdata(hdr_tdata), .hdr_tkeep(hdr_tkeep), .hdr_tlast(hdr_tlast),
    .hdr_tvalid(hdr_tvalid), .hdr_tready(hdr_tready),
    .bdy_tdata(bdy_tdata), .bdy_tkeep(bdy_tkeep), .bdy_tlast(bdy_tlast),
    .bdy_tvalid(bdy_tvalid), .bdy_tready(bdy_tready),
    .out_tdata(out_tdata), .out_tkeep(out_tkeep), .out_tlast(out_tlast),
    .out_tvalid(out_tvalid), .out_tuser(out_tuser), .out_tready(out_tready),
    .req_done(req_done), .region_stats_out(region_stats_out)
`ifdef LB_DISPATCH_DROP_CNT_EN
    , .drop_cnt(drop_cnt)
`endif
  );

  lb_dispatcher #(.N_REGIONS(4), .OPERATOR_ID_WIDTH(4), .DATA_BITS(8)) dut_s (
    .aclk(aclk), .aresetn(aresetn),
    .lb_ctrl(s_lb_ctrl), .lb_ctrl_valid(s_lb_ctrl_valid), .lb_ctrl_ready(s_lb_ctrl_ready),
    .hdr_tdata(s_hdr_tdata), .hdr_tkeep(s_hdr_tkeep), .hdr_tlast(s_hdr_tlast),
    .hdr_tvalid(s_hdr_tvalid), .hdr_tready(s_hdr_tready),
    .bdy_tdata(s_bdy_tdata), .bdy_tkeep(s_bdy_tkeep), .bdy_tlast(s_bdy_tlast),
    .bdy_tvalid(s_bdy_tvalid), .bdy_tready(s_bdy_tready),
    .out_tdata(s_out_tdata), .out_tkeep(s_out_tkeep), .out_tlast(s_out_tlast),
    .out_tvalid(s_out_tvalid), .out_tuser(s_out_tuser), .out_tready(s_out_tready),
    .req_done(s_req_done), .region_stats_out(s_stats)
`ifdef LB_DISPATCH_DROP_CNT_EN
    , .drop_cnt(s_drop_cnt)
`endif
  );

  typedef struct {
    logic [31:0] ctrl;
    int          nh;
    int          nb;
    int          reg_idx;    // -1: invalid region, packet is dropped
    int          stall;      // cycles of out_tready low on header beat 1
    logic [3:0]  done;       // req_done pulsed in the accept cycle
    logic [63:0] exp_stats;
    logic [15:0] exp_drop;
  } vec_t;

  vec_t vecs[12];

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] beat_data(input logic [31:0] c, input int ph, input int b);
    return {c, 8'(ph), 8'hA5, 16'(b)};
  endfunction

  task automatic check_beat(input string tag, input logic is_bdy, input int reg_idx,
                            input logic [3:0] exp_vld, input logic [63:0] d,
                            input logic [7:0] k, input logic l, input logic exp_rdy);
    check({tag, "_tvalid"}, out_tvalid, exp_vld);
    check({tag, "_tuser"}, out_tuser, is_bdy ? exp_vld : 4'b0);
    check({tag, "_hdr_tready"}, hdr_tready, !is_bdy && exp_rdy);
    check({tag, "_bdy_tready"}, bdy_tready, is_bdy && exp_rdy);
    if (reg_idx >= 0) begin
      check({tag, "_tdata"}, out_tdata[reg_idx*D +: D], d);
      check({tag, "_tkeep"}, out_tkeep[reg_idx*KB +: KB], k);
      check({tag, "_tlast"}, out_tlast[reg_idx], l);
    end else begin
      check({tag, "_tdata_dropped"}, out_tdata, 256'b0);
    end
  endtask

  task automatic send_pkt(input vec_t v);
    int         waited;
    logic [3:0] exp_vld;
    logic [63:0] d;
    logic [7:0] k;
    exp_vld = (v.reg_idx < 0) ? 4'b0 : 4'(1 << v.reg_idx);
    @(negedge aclk);
    lb_ctrl = v.ctrl; lb_ctrl_valid = 1'b1;
    hdr_tvalid = 1'b1; hdr_tlast = 1'b0; hdr_tdata = beat_data(v.ctrl, 0, 0);
    #1;
    waited = 0;
    while (lb_ctrl_ready !== 1'b1 && waited < 20) begin
      @(negedge aclk); #1; waited++;
    end
    check("ctrl_accept", lb_ctrl_ready, 1'b1);
    check("hdr_tready_in_accept_cycle", hdr_tready, 1'b0);
    check("out_tvalid_in_accept_cycle", out_tvalid, 4'b0);
    req_done = v.done;
    @(negedge aclk);
    lb_ctrl_valid = 1'b0; req_done = '0;
    #1;
    check("ctrl_ready_busy", lb_ctrl_ready, 1'b0);
    check("stats_one_cycle_after_accept", region_stats_out, v.exp_stats);
    for (int b = 0; b < v.nh; b++) begin
      d = beat_data(v.ctrl, 1, b); k = 8'hFF >> b;
      hdr_tdata = d; hdr_tkeep = k; hdr_tlast = (b == v.nh - 1); hdr_tvalid = 1'b1;
      if (b == 1 && v.stall > 0 && v.reg_idx >= 0) begin
        out_tready[v.reg_idx] = 1'b0;
        for (int s = 0; s < v.stall; s++) begin
          #1;
          check("stall_hdr_tready", hdr_tready, 1'b0);
          check("stall_out_tvalid", out_tvalid, exp_vld);
          check("stall_tdata_held", out_tdata[v.reg_idx*D +: D], d);
          @(negedge aclk);
        end
        out_tready = '1;
      end
      #1;
      check_beat("hdr", 1'b0, v.reg_idx, exp_vld, d, k, hdr_tlast, 1'b1);
      @(negedge aclk);
    end
    hdr_tvalid = 1'b0; hdr_tlast = 1'b0;
    for (int b = 0; b < v.nb; b++) begin
      d = beat_data(v.ctrl, 2, b); k = 8'hFF << b;
      bdy_tdata = d; bdy_tkeep = k; bdy_tlast = (b == v.nb - 1); bdy_tvalid = 1'b1;
      #1;
      check_beat("bdy", 1'b1, v.reg_idx, exp_vld, d, k, bdy_tlast, 1'b1);
      @(negedge aclk);
    end
    bdy_tvalid = 1'b0; bdy_tlast = 1'b0;
    #1;
    check("ctrl_ready_after_pkt", lb_ctrl_ready, 1'b1);
    check("out_tvalid_after_pkt", out_tvalid, 4'b0);
    check("stats_after_pkt", region_stats_out, v.exp_stats);
`ifdef LB_DISPATCH_DROP_CNT_EN
    check("drop_cnt", drop_cnt, v.exp_drop);
`endif
    $display("pkt ctrl=%08h region=%0d hdr=%0d bdy=%0d done=%b stats=%016h",
             v.ctrl, v.reg_idx, v.nh, v.nb, v.done, region_stats_out);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int waited;
    logic [3:0] exp_cnt;

    vecs[0]  = '{32'h0007_0001, 2, 2, -1, 0, 4'b0000, 64'h0000_0000_0000_0000, 16'd1};
    vecs[1]  = '{32'h0002_00AA, 2, 3,  2, 0, 4'b0000, 64'h0000_0001_0000_0000, 16'd1};
    vecs[2]  = '{32'h0001_0033, 3, 2,  1, 3, 4'b0000, 64'h0000_0001_0001_0000, 16'd1};
    vecs[3]  = '{32'h0000_0010, 1, 1,  0, 0, 4'b0000, 64'h0000_0001_0001_0001, 16'd1};
    vecs[4]  = '{32'h0000_0011, 1, 2,  0, 0, 4'b0000, 64'h0000_0001_0001_0002, 16'd1};
    vecs[5]  = '{32'h0000_0012, 2, 1,  0, 0, 4'b0000, 64'h0000_0001_0001_0003, 16'd1};
    vecs[6]  = '{32'h0000_0013, 1, 1,  0, 0, 4'b0000, 64'h0000_0001_0001_0004, 16'd1};
    vecs[7]  = '{32'h0000_0014, 1, 1,  0, 0, 4'b0000, 64'h0000_0001_0001_0005, 16'd1};
    vecs[8]  = '{32'h0000_0015, 1, 1,  0, 0, 4'b0001, 64'h0000_0001_0001_0005, 16'd1};
    vecs[9]  = '{32'h0004_0000, 1, 1, -1, 0, 4'b0000, 64'h0000_0001_0001_0005, 16'd2};
    vecs[10] = '{32'hFFFF_FFFF, 1, 3, -1, 0, 4'b0000, 64'h0000_0001_0001_0005, 16'd3};
    vecs[11] = '{32'h0003_BEEF, 1, 1,  3, 0, 4'b0100, 64'h0001_0000_0001_0005, 16'd3};

    aresetn = 1'b0;
    lb_ctrl = '0; lb_ctrl_valid = 1'b0;
    hdr_tdata = '0; hdr_tkeep = '0; hdr_tlast = 1'b0; hdr_tvalid = 1'b0;
    bdy_tdata = '0; bdy_tkeep = '0; bdy_tlast = 1'b0; bdy_tvalid = 1'b0;
    out_tready = '1; req_done = '0;
    s_lb_ctrl = '0; s_lb_ctrl_valid = 1'b0;
    s_hdr_tdata = 8'h11; s_hdr_tkeep = 1'b1; s_hdr_tlast = 1'b0; s_hdr_tvalid = 1'b0;
    s_bdy_tdata = 8'h22; s_bdy_tkeep = 1'b1; s_bdy_tlast = 1'b0; s_bdy_tvalid = 1'b0;
    s_out_tready = 4'hF; s_req_done = '0;

    repeat (3) @(negedge aclk);
    check("rst_ctrl_ready", lb_ctrl_ready, 1'b0);
    check("rst_out_tvalid", out_tvalid, 4'b0);
    check("rst_hdr_tready", hdr_tready, 1'b0);
    check("rst_bdy_tready", bdy_tready, 1'b0);
    check("rst_stats", region_stats_out, 64'h0);
    aresetn = 1'b1;
    @(negedge aclk); #1;
    check("post_rst_ctrl_ready", lb_ctrl_ready, 1'b1);

    // decrement of an empty counter stays at zero
    req_done = 4'b1000;
    @(negedge aclk); req_done = '0; #1;
    check("stats3_floor", region_stats_out, 64'h0);
    $display("done pulse region=3 stats=%016h", region_stats_out);

    for (int i = 0; i < 12; i++) send_pkt(vecs[i]);

    @(negedge aclk); req_done = 4'b0010;
    @(negedge aclk); req_done = '0; #1;
    check("stats_dec_region1", region_stats_out, 64'h0001_0000_0000_0005);
    $display("done pulse region=1 stats=%016h", region_stats_out);
    req_done = 4'b1001;
    @(negedge aclk); req_done = '0; #1;
    check("stats_dec_region0_3", region_stats_out, 64'h0000_0000_0000_0004);
    $display("done pulse regions=0,3 stats=%016h", region_stats_out);

    // reset in the middle of a body transfer
    lb_ctrl = 32'h0001_0055; lb_ctrl_valid = 1'b1;
    @(negedge aclk); lb_ctrl_valid = 1'b0;
    hdr_tdata = beat_data(32'h0001_0055, 1, 0); hdr_tkeep = '1; hdr_tlast = 1'b1; hdr_tvalid = 1'b1;
    @(negedge aclk);
    hdr_tvalid = 1'b0; hdr_tlast = 1'b0;
    bdy_tdata = beat_data(32'h0001_0055, 2, 0); bdy_tkeep = '1; bdy_tlast = 1'b0; bdy_tvalid = 1'b1;
    #1;
    check("mid_bdy_out_tvalid", out_tvalid, 4'b0010);
    check("mid_bdy_stats", region_stats_out, 64'h0000_0000_0001_0004);
    #2 aresetn = 1'b0;
    #1;
    check("async_rst_out_tvalid", out_tvalid, 4'b0);
    check("async_rst_out_tdata", out_tdata, 256'b0);
    check("async_rst_out_tuser", out_tuser, 4'b0);
    check("async_rst_bdy_tready", bdy_tready, 1'b0);
    check("async_rst_hdr_tready", hdr_tready, 1'b0);
    check("async_rst_ctrl_ready", lb_ctrl_ready, 1'b0);
    check("async_rst_stats", region_stats_out, 64'h0);
`ifdef LB_DISPATCH_DROP_CNT_EN
    check("async_rst_drop_cnt", drop_cnt, 16'd0);
`endif
    @(negedge aclk); aresetn = 1'b1;
    @(negedge aclk); #1;
    check("post_mid_rst_ctrl_ready", lb_ctrl_ready, 1'b1);
    check("post_mid_rst_bdy_tready", bdy_tready, 1'b0);
    check("post_mid_rst_out_tvalid", out_tvalid, 4'b0);
    check("post_mid_rst_stats", region_stats_out, 64'h0);
    bdy_tvalid = 1'b0;
    $display("reset during body: stats=%016h ready=%b", region_stats_out, lb_ctrl_ready);

    // saturation at all-ones on the 4-bit counter instance, region 3
    s_hdr_tvalid = 1'b1; s_hdr_tlast = 1'b1; s_bdy_tvalid = 1'b1; s_bdy_tlast = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      @(negedge aclk);
      s_lb_ctrl = 8'h30; s_lb_ctrl_valid = 1'b1;
      #1;
      waited = 0;
      while (s_lb_ctrl_ready !== 1'b1 && waited < 20) begin
        @(negedge aclk); #1; waited++;
      end
      check("sat_accept", s_lb_ctrl_ready, 1'b1);
      @(negedge aclk); s_lb_ctrl_valid = 1'b0; #1;
      exp_cnt = (k > 15) ? 4'hF : 4'(k);
      check("sat_stats3", s_stats, {exp_cnt, 12'h000});
      $display("narrow pkt %0d region=3 stats=%04h", k, s_stats);
    end
    repeat (3) @(negedge aclk);
    s_hdr_tvalid = 1'b0; s_bdy_tvalid = 1'b0;
    s_req_done = 4'b1000;
    @(negedge aclk); s_req_done = '0; #1;
    check("sat_dec_from_max", s_stats, 16'hE000);
    $display("narrow done region=3 stats=%04h", s_stats);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/lb_dispatcher.md
LB_DISPATCHER -- requirements
Module: lb_dispatcher

Interface
REQ-001 SHALL have parameter N_REGIONS, default 4: number of downstream regions.
REQ-002 SHALL have parameter OPERATOR_ID_WIDTH, default 16: width of the operator/region ID fields and of each stats counter.
REQ-003 SHALL have parameter DATA_BITS, default 512: stream data width.
REQ-004 SHALL have ports aclk (in, 1): the single clock; aresetn (in, 1): asynchronous, active-low reset.
REQ-005 SHALL have ports lb_ctrl (in, 2*OPERATOR_ID_WIDTH), lb_ctrl_valid (in, 1), lb_ctrl_ready (out, 1); upper half = region index, lower half = operator ID.
REQ-006 SHALL have ports hdr_tdata/tkeep/tlast/tvalid (in; DATA_BITS, DATA_BITS/8, 1, 1) and hdr_tready (out, 1).
REQ-007 SHALL have ports bdy_tdata/tkeep/tlast/tvalid (in; same widths) and bdy_tready (out, 1).
REQ-008 SHALL have ports out_tdata (out, N_REGIONS*DATA_BITS), out_tkeep (out, N_REGIONS*DATA_BITS/8), out_tlast/out_tvalid/out_tuser (out, N_REGIONS each), out_tready (in, N_REGIONS); tuser=1 marks a body beat.
REQ-009 SHALL have port req_done (in, N_REGIONS): one-cycle completion pulse per region.
REQ-010 SHALL have port region_stats_out (out, N_REGIONS*OPERATOR_ID_WIDTH): region i occupies bits [i*W +: W].

Function
REQ-011 SHALL implement an FSM with states IDLE, HDR, BDY, DROP_HDR, DROP_BDY.
REQ-012 SHALL assert lb_ctrl_ready only in IDLE; the request is accepted on the cycle where lb_ctrl_valid & lb_ctrl_ready.
REQ-013 SHALL, on accept, latch the region index and operator ID and go to HDR if region < N_REGIONS, else to DROP_HDR.
REQ-014 SHALL, in HDR, combinationally route the header stream to the selected region: out_tvalid[sel]=hdr_tvalid, hdr_tready=out_tready[sel], tuser=0; leave every other region's out_tvalid at 0.
REQ-015 SHALL move HDR->BDY on an accepted header beat with tlast=1.
REQ-016 SHALL route the body stream identically in BDY with tuser=1, and move BDY->IDLE on an accepted body beat with tlast=1.
REQ-017 SHALL, in DROP_HDR/DROP_BDY, hold hdr_tready/bdy_tready at 1, drive no output valid, and follow the same tlast transitions.
REQ-018 SHALL hold bdy_tready=0 outside BDY/DROP_BDY and hdr_tready=0 outside HDR/DROP_HDR.
REQ-019 SHALL increment region stats counter [sel] by 1 on the accept cycle of a valid-region request.
REQ-020 SHALL decrement counter [i] by 1 on req_done[i].
REQ-021 SHALL leave a counter unchanged when increment and decrement for it coincide in the same cycle.
REQ-022 SHALL saturate counters at all-ones on increment and at 0 on decrement.
REQ-023 SHALL register region_stats_out, so it reflects a counter change one cycle after the triggering event.
REQ-024 SHALL start the first header beat no earlier than the cycle after accept.

Reset
REQ-025 SHALL, while aresetn=0, immediately force the FSM to IDLE, all counters and region_stats_out to 0, all out_tvalid/hdr_tready/bdy_tready to 0, and lb_ctrl_ready to 0.
REQ-026 SHALL abandon any in-flight transfer on reset mid-packet; no resumption after release.

Configuration
REQ-027 SHALL, with LB_DISPATCH_DROP_CNT_EN defined, add output drop_cnt (OPERATOR_ID_WIDTH), reset to 0, incremented (saturating) on each accepted invalid-region request; without the macro the port and counter are absent and behaviour is otherwise identical.

Structure
REQ-028 SHALL place the FSM state enum and region-index/ID field-extraction constants in shared package lb_pkg.
REQ-029 SHALL use one sub-module, lb_region_counter (a single saturating up/down counter), instantiated N_REGIONS times.

Verification
REQ-030 Test: lb_ctrl=0x0002_00AA, 2-beat header, 3-beat body, all out_tready=1 -> region 2 emits 2 beats with tuser=0 then 3 with tuser=1; stats[2]=1.
REQ-031 Test: lb_ctrl=0x0007_0001 (invalid region) -> hdr and bdy are drained, no out_tvalid is asserted, drop_cnt=1 (macro on), all stats=0.
REQ-032 Test: out_tready[1]=0 for 3 cycles mid-header to region 1 -> hdr_tready=0 and the data is held stable until ready.
REQ-033 Test: stats[0]=5, then req_done[0] in the same cycle as a region-0 accept -> stats[0] stays 5.
REQ-034 Test: stats[3]=0 then req_done[3] -> stays 0; stats[3]=0xFFFF then accept -> stays 0xFFFF.
REQ-035 Test: assert aresetn=0 during BDY -> all outputs are 0 at once; after release lb_ctrl_ready=1 and stats=0.
